stream_id_demux: RTL and testbench

STREAM_ID_DEMUX -- requirements
Module: stream_id_demux

---
 rtl/stream_id_demux.sv | 164 ++++++++++++++++
 tb/tb_stream_id_demux.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_id_demux.sv
// Routes a single input beat stream to one of STREAM_COUNT outputs by id.
// Each output has a 2-entry skid buffer; a packet FSM locks the id until the last beat.

module stream_id_demux_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         ready_i,
  output logic         full_o,
  output logic         valid_o,
  output logic [W-1:0] dout_o
);
  logic [1:0]   cnt;
  logic [W-1:0] e0, e1;
  logic         pop;

  assign valid_o = (cnt != 2'd0);
  assign full_o  = (cnt == 2'd2);
  assign dout_o  = e0;
  assign pop     = valid_o & ready_i;

  // e0 is always the head; e1 only holds data while two entries are queued
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push_i, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din_i;
          else             e1 <= din_i;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= din_i;
          end else begin
            e0 <= din_i;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module stream_id_demux #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [T_DATA_WIDTH-1:0]                   s_data_i,
  input  logic [T_QOS__WIDTH-1:0]                   s_qos_i,
  input  logic [T_ID___WIDTH-1:0]                   s_id_i,
  input  logic                                      s_last_i,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
  output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] m_qos_o,
  output logic [STREAM_COUNT-1:0]                   m_last_o,
  output logic [STREAM_COUNT-1:0]                   m_valid_o,
  input  logic [STREAM_COUNT-1:0]                   m_ready_i,
  output logic                                      err_o
);
  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_QOS__WIDTH-1:0] qos;
    logic                    last;
  } beat_t;

  localparam int BW = $bits(beat_t);
  localparam logic [T_ID___WIDTH:0] SC = (T_ID___WIDTH+1)'(STREAM_COUNT);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  logic [0:0]              state;
  logic [T_ID___WIDTH-1:0] lock_id;
  logic                    drop_q;
  logic                    err_q;

  logic                    in_pkt, id_ok, drop, sel_full, acc, id_err;
  logic [T_ID___WIDTH-1:0] dest;
  logic [STREAM_COUNT-1:0] full, push;
  beat_t                   beat_in;
  beat_t [STREAM_COUNT-1:0] beat_out;

  assign beat_in = '{data: s_data_i, qos: s_qos_i, last: s_last_i};
  assign id_ok   = ({1'b0, s_id_i} < SC);
  assign in_pkt  = (state == IN_PKT);
  assign dest    = in_pkt ? lock_id : s_id_i;
  assign drop    = in_pkt ? drop_q : ~id_ok;
  assign id_err  = in_pkt ? (s_id_i != lock_id) : ~id_ok;

  // Ready looks only at stored occupancy, never at m_ready_i, so there is
  // no combinational path from the output side back to the input.
  always_comb begin
    sel_full = 1'b0;
    for (int k = 0; k < STREAM_COUNT; k++)
      if (dest == T_ID___WIDTH'(k)) sel_full = full[k];
  end

  assign s_ready_o = ~rst_i & (drop | ~sel_full);
  assign acc       = s_valid_i & s_ready_o;
  assign err_o     = err_q;

  for (genvar k = 0; k < STREAM_COUNT; k++) begin : g_lane
    assign push[k] = acc & ~drop & (dest == T_ID___WIDTH'(k));

    stream_id_demux_skid #(.W(BW)) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[k]),
      .din_i   (beat_in),
      .ready_i (m_ready_i[k]),
      .full_o  (full[k]),
      .valid_o (m_valid_o[k]),
      .dout_o  (beat_out[k])
    );

    assign m_data_o[k] = beat_out[k].data;
    assign m_qos_o[k]  = beat_out[k].qos;
    assign m_last_o[k] = beat_out[k].last;
  end

  // An out-of-range id at packet start turns the whole packet into a drop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      lock_id <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (acc) begin
      if (id_err) err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (!s_last_i) begin
            state   <= IN_PKT;
            lock_id <= s_id_i;
            drop_q  <= ~id_ok;
          end
        end
        IN_PKT: begin
          if (s_last_i) begin
            state  <= IDLE;
            drop_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_id_demux.sv
// Directed + random bench for stream_id_demux; a queue-based packet model
// predicts ready, per-output contents and the error flag.

module tb_stream_id_demux;
  localparam int NS = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       s_data;
  logic [3:0]       s_qos;
  logic [0:0]       s_id;
  logic             s_last, s_valid, s_ready;
  logic [NS-1:0][7:0] m_data;
  logic [NS-1:0][3:0] m_qos;
  logic [NS-1:0]    m_last, m_valid, m_ready;
  logic             err;

  logic [7:0]       b_data;
  logic [3:0]       b_qos;
  logic [1:0]       b_id;
  logic             b_last, b_valid, b_ready;
  logic [2:0][7:0]  b_m_data;
  logic [2:0][3:0]  b_m_qos;
  logic [2:0]       b_m_last, b_m_valid, b_m_ready;
  logic             b_err;

  always #5 clk = ~clk;

  stream_id_demux dut (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_qos_i(s_qos), .s_id_i(s_id),
    .s_last_i(s_last), .s_valid_i(s_valid), .s_ready_o(s_ready), .m_data_o(m_data),
    .m_qos_o(m_qos), .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .err_o(err)
  );

  stream_id_demux #(.STREAM_COUNT(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .s_data_i(b_data), .s_qos_i(b_qos), .s_id_i(b_id),
    .s_last_i(b_last), .s_valid_i(b_valid), .s_ready_o(b_ready), .m_data_o(b_m_data),
    .m_qos_o(b_m_qos), .m_last_o(b_m_last), .m_valid_o(b_m_valid), .m_ready_i(b_m_ready),
    .err_o(b_err)
  );

  typedef struct { logic [7:0] d; logic [3:0] q; logic l; } bt;
  bt  mq[NS][$];
  bit m_inpkt, m_drop, m_err;
  int m_lock;
  int errors = 0, checks = 0, dut_out_cnt = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, int id, int d, int q, bit l, logic [1:0] mr);
    s_valid = v; s_id = 1'(id); s_data = 8'(d); s_qos = 4'(q); s_last = l; m_ready = mr;
  endtask

  // Check the current cycle against the model, advance the model across the
  // coming clock edge, and return at the following falling edge.
  task automatic tick(output bit acc);
    bit drop, exp_rdy;
    int dest;
    bt  b;
    #1;
    for (int k = 0; k < NS; k++) begin
      chk("m_valid", 32'(m_valid[k]), 32'(mq[k].size() > 0));
      if (mq[k].size() > 0) begin
        chk("m_data", 32'(m_data[k]), 32'(mq[k][0].d));
        chk("m_qos",  32'(m_qos[k]),  32'(mq[k][0].q));
        chk("m_last", 32'(m_last[k]), 32'(mq[k][0].l));
      end
      if (m_valid[k] && m_ready[k]) dut_out_cnt++;
    end
    chk("err", 32'(err), 32'(m_err));
    dest    = m_inpkt ? m_lock : int'(s_id);
    drop    = m_inpkt ? m_drop : (int'(s_id) >= NS);
    exp_rdy = !rst && (drop || mq[dest].size() < 2);
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
    acc = s_valid && exp_rdy;
    if (rst) begin
      for (int k = 0; k < NS; k++) mq[k].delete();
      m_inpkt = 0; m_drop = 0; m_err = 0; m_lock = 0;
    end else begin
      for (int k = 0; k < NS; k++)
        if (mq[k].size() > 0 && m_ready[k]) void'(mq[k].pop_front());
      if (acc) begin
        if (m_inpkt ? (int'(s_id) != m_lock) : (int'(s_id) >= NS)) m_err = 1;
        if (!drop) begin
          b.d = s_data; b.q = s_qos; b.l = s_last;
          mq[dest].push_back(b);
        end
        if (!m_inpkt && !s_last) begin
          m_inpkt = 1; m_lock = int'(s_id); m_drop = (int'(s_id) >= NS);
        end else if (m_inpkt && s_last) begin
          m_inpkt = 0; m_drop = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(int id, int d, int q, bit l, logic [1:0] mr);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 50) begin
      drive(1, id, d, q, l, mr);
      tick(acc);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $error("FAIL send_timeout: got not-accepted expected accepted");
    end
    drive(0, 0, 0, 0, 0, mr);
  endtask

  task automatic idle(int n, logic [1:0] mr);
    bit acc;
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, mr);
      tick(acc);
    end
  endtask

  initial begin
    bit acc;
    rst = 1;
    drive(0, 0, 0, 0, 0, 2'b00);
    b_valid = 0; b_id = 0; b_data = 0; b_qos = 0; b_last = 0; b_m_ready = 3'b111;
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data",  32'(m_data), 0);
    chk("rst_qos",   32'(m_qos), 0);
    chk("rst_last",  32'(m_last), 0);
    chk("rst_err",   32'(err), 0);
    tick(acc);
    rst = 0;
    #1;
    chk("post_rst_ready", 32'(s_ready), 1);

    // single beat to output 1
    send(1, 8'hA5, 3, 1, 2'b11);
    chk("single_valid", 32'(m_valid), 32'(2'b10));
    chk("single_data",  32'(m_data[1]), 32'hA5);
    chk("single_qos",   32'(m_qos[1]), 3);
    chk("single_last",  32'(m_last[1]), 1);
    idle(2, 2'b11);

    // backpressure: two beats fill output 0, then ready drops
    send(0, 1, 0, 0, 2'b00);
    send(0, 2, 0, 0, 2'b00);
    drive(1, 0, 3, 0, 0, 2'b00);
    #1;
    chk("bp_ready_low", 32'(s_ready), 0);
    tick(acc);
    send(0, 3, 0, 0, 2'b01);
    send(0, 4, 0, 1, 2'b01);
    idle(3, 2'b01);
    chk("bp_err", 32'(err), 0);

    // id mismatch inside a packet stays on the locked output
    send(0, 8'h10, 1, 0, 2'b11);
    send(1, 8'h11, 1, 0, 2'b11);
    send(0, 8'h12, 1, 1, 2'b11);
    idle(2, 2'b11);
    chk("mismatch_err", 32'(err), 1);
    idle(3, 2'b11);
    chk("mismatch_err_sticky", 32'(err), 1);

    // out-of-range id on the 3-output instance is dropped for the whole packet
    b_valid = 1; b_id = 3; b_last = 0; b_data = 8'h11;
    #1;
    chk("oor_ready0", 32'(b_ready), 1);
    tick(acc);
    b_last = 1; b_data = 8'h22;
    #1;
    chk("oor_ready1", 32'(b_ready), 1);
    tick(acc);
    b_valid = 0;
    chk("oor_valid0", 32'(b_m_valid), 0);
    tick(acc);
    chk("oor_valid1", 32'(b_m_valid), 0);
    chk("oor_err", 32'(b_err), 1);
    b_valid = 1; b_id = 2; b_last = 1; b_data = 8'h3C; b_qos = 5;
    #1;
    chk("oor_next_ready", 32'(b_ready), 1);
    tick(acc);
    b_valid = 0;
    chk("oor_next_valid", 32'(b_m_valid), 32'(3'b100));
    chk("oor_next_data",  32'(b_m_data[2]), 32'h3C);
    chk("oor_next_qos",   32'(b_m_qos[2]), 5);
    tick(acc);

    // back-to-back alternating ids
    dut_out_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, i % 2, 8'h40 + i, i, 1, 2'b11);
      #1;
      chk("b2b_ready", 32'(s_ready), 1);
      tick(acc);
    end
    idle(2, 2'b11);
    chk("b2b_out_cnt", 32'(dut_out_cnt), 20);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom, $urandom,
            $urandom_range(0, 2) == 0, 2'($urandom));
      tick(acc);
    end
    send(0, 0, 0, 1, 2'b11);
    idle(4, 2'b11);

    // reset mid-packet with both buffers full
    send(0, 1, 0, 0, 2'b00);
    send(0, 2, 0, 1, 2'b00);
    send(1, 3, 0, 0, 2'b00);
    send(1, 4, 0, 0, 2'b00);
    chk("pre_rst_valid", 32'(m_valid), 32'(2'b11));
    rst = 1;
    drive(0, 0, 0, 0, 0, 2'b00);
    tick(acc);
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_err", 32'(err), 0);
    rst = 0;
    send(1, 8'h77, 9, 1, 2'b00);
    chk("after_rst_valid", 32'(m_valid), 32'(2'b10));
    chk("after_rst_data",  32'(m_data[1]), 32'h77);
    idle(3, 2'b11);
    chk("final_empty", 32'(m_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
